// File: rtl/mdu_pkg.sv
// Shared encodings for the RV32M multiply/divide sequencer: Funct3 ops, MCycle opcodes,
// FSM states and the signed-division overflow dividend.
package mdu_pkg;

  typedef enum logic [2:0] {
    F3Mul    = 3'd0,
    F3Mulh   = 3'd1,
    F3Mulhsu = 3'd2,
    F3Mulhu  = 3'd3,
    F3Div    = 3'd4,
    F3Divu   = 3'd5,
    F3Rem    = 3'd6,
    F3Remu   = 3'd7
  } funct3_e;

  typedef enum logic [1:0] {
    McMulU = 2'b00,
    McMulS = 2'b01,
    McDivU = 2'b10,
    McDivS = 2'b11
  } mc_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic [31:0] DivOvfDividend = 32'h8000_0000;

  // MULHSU runs as an unsigned multiply; the sign of rs1 is corrected afterwards.
  function automatic mc_op_e mc_op_of(funct3_e f);
    mc_op_e op;
    unique case (f)
      F3Mul, F3Mulh:     op = McMulS;
      F3Mulhsu, F3Mulhu: op = McMulU;
      F3Div, F3Rem:      op = McDivS;
      F3Divu, F3Remu:    op = McDivU;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mdu_sequencer.sv
// Drives the multi-cycle MUL/DIV unit for RV32M ops: stalls the core while busy, resolves
// divide-by-zero/overflow locally and emits one write strobe per M instruction.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic               MValid,
  input  logic [2:0]         Funct3,
  input  logic [WIDTH-1:0]   SrcA,
  input  logic [WIDTH-1:0]   SrcB,
  output logic               Stall,
  output logic               MWrite,
  output logic [WIDTH-1:0]   MResult,
  output logic               Start,
  output logic [1:0]         MCycleOp,
  output logic [WIDTH-1:0]   Operand1,
  output logic [WIDTH-1:0]   Operand2,
  input  logic               MC_Busy,
  input  logic [2*WIDTH-1:0] MC_Result,
  output logic               Timeout
);

  localparam int unsigned      CntW        = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0]  CntMax      = CntW'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] OvfDividend = WIDTH'(DivOvfDividend);

  state_e           state_q, state_d;
  funct3_e          f3_q, f3_d;
  logic             a_sign_q, a_sign_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             to_q, to_d;

  logic             is_div, is_rem, is_signed_div, div_zero, div_ovf, fast;
  logic [WIDTH-1:0] fast_res, sel_res, mc_hi, mc_lo;
  logic             stall, start, mwrite;

  // Among div ops Funct3[1] marks REM*, Funct3[0] marks the unsigned forms.
  assign is_div        = Funct3[2];
  assign is_rem        = Funct3[1];
  assign is_signed_div = is_div & ~Funct3[0];
  assign div_zero      = is_div && (SrcB == '0);
  assign div_ovf       = is_signed_div && (SrcA == OvfDividend) && (SrcB == '1);
  assign fast          = div_zero | div_ovf;

  always_comb begin
    fast_res = '0;
    if (div_zero) begin
      fast_res = is_rem ? SrcA : '1;
    end else begin
      fast_res = is_rem ? '0 : OvfDividend;
    end
  end

  assign mc_hi = MC_Result[2*WIDTH-1:WIDTH];
  assign mc_lo = MC_Result[WIDTH-1:0];

  always_comb begin
    sel_res = '0;
    unique case (f3_q)
      F3Mul, F3Div, F3Divu:    sel_res = mc_lo;
      F3Mulh, F3Mulhu:         sel_res = mc_hi;
      F3Rem, F3Remu:           sel_res = mc_hi;
      // Unsigned product of a negative rs1 over-counts by rs2 * 2^WIDTH.
      F3Mulhsu:                sel_res = mc_hi - (a_sign_q ? b_q : '0);
    endcase
  end

  always_comb begin
    state_d  = state_q;
    f3_d     = f3_q;
    a_sign_d = a_sign_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    to_d     = to_q;
    stall    = 1'b0;
    start    = 1'b0;
    mwrite   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (MValid) begin
          stall = 1'b1;
          if (fast) begin
            res_d   = fast_res;
            state_d = StDone;
          end else begin
            start    = 1'b1;
            f3_d     = funct3_e'(Funct3);
            a_sign_d = SrcA[WIDTH-1];
            b_d      = SrcB;
            cnt_d    = '0;
            state_d  = StWait;
          end
        end
      end
      StWait: begin
        stall = 1'b1;
        if (!MC_Busy) begin
          res_d   = sel_res;
          state_d = StDone;
        end else if (cnt_q == CntMax) begin
          res_d   = '0;
          to_d    = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        mwrite  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q  <= StIdle;
      f3_q     <= F3Mul;
      a_sign_q <= 1'b0;
      b_q      <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      f3_q     <= f3_d;
      a_sign_q <= a_sign_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      to_q     <= to_d;
    end
  end

  // Combinational outputs are masked so an asserted reset silences them at once.
  assign Stall    = stall & ~Reset;
  assign Start    = start & ~Reset;
  assign MWrite   = mwrite & ~Reset;
  assign MResult  = res_q;
  assign Timeout  = to_q;
  assign MCycleOp = mc_op_of(funct3_e'(Funct3));
  assign Operand1 = SrcA;
  assign Operand2 = SrcB;

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Sequences the multi-cycle multiply/divide unit (MCycle: Start/Busy handshake, 2×WIDTH result) for RV32M instructions in the single-cycle core.
- Stalls PC and register write while the unit is busy.
- Handles the RISC-V divide-by-zero and signed-overflow cases without starting the unit.
- Performs the MULHSU correction, then delivers one write strobe and result per M instruction.

Parameters:
WIDTH, 32, datapath width
TIMEOUT, 64, max cycles in WAIT before forced abort

Ports:
CLK  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high reset
MValid  in  1  decoder: current Instr is an M-extension op (opcode 0110011, funct7 0000001)
Funct3  in  3  Instr[14:12]: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
SrcA  in  WIDTH  rs1 value (Src_A)
SrcB  in  WIDTH  rs2 value (RD2, unshifted)
Stall  out  1  hold PC and suppress normal RegWrite
MWrite  out  1  one-cycle register-file write strobe for MResult
MResult  out  WIDTH  M-op result, valid when MWrite=1
Start  out  1  MCycle start pulse
MCycleOp  out  2  00 mul unsigned, 01 mul signed, 10 div unsigned, 11 div signed
Operand1  out  WIDTH  to MCycle, = SrcA
Operand2  out  WIDTH  to MCycle, = SrcB
MC_Busy  in  1  MCycle busy; must be high in the same cycle Start is sampled
MC_Result  in  2*WIDTH  product {hi,lo}, or {remainder,quotient}
Timeout  out  1  sticky abort flag, cleared only by Reset

Behaviour:
Clock and reset:
- One clock, CLK. Reset is asynchronous, active-high.
- Reset forces: state IDLE; Stall=0, MWrite=0, Start=0, MResult=0, Timeout=0, cycle counter=0.
- Reset mid-operation aborts with no write; MCycle shares the same Reset.

State machine (IDLE, WAIT, DONE):
- IDLE, MValid=0: all outputs inactive.
- IDLE, MValid=1, fast case:
  - Fast cases: DIV/DIVU/REM/REMU with SrcB=0; DIV/REM with SrcA=0x80000000 and SrcB=0xFFFFFFFF.
  - Stall=1 combinationally, Start=0.
  - Register the fast result, go to DONE.
- IDLE, MValid=1, normal case:
  - Stall=1 and Start=1, both combinational.
  - Latch Funct3 and SrcA[WIDTH-1] (for MULHSU) and SrcB.
  - Go to WAIT and clear the counter.
- WAIT:
  - Stall=1, Start=0.
  - MC_Busy=0: register the selected result, go to DONE.
  - Counter reaches TIMEOUT-1 with MC_Busy still 1: MResult=0, Timeout set, go to DONE.
- DONE:
  - Stall=0, MWrite=1 for exactly one cycle; the core advances PC at this edge.
  - Go to IDLE unconditionally. No Start in DONE, even though MValid is still high for the same instruction.

MCycleOp mapping:
- MUL, MULH: 01.
- MULHSU, MULHU: 00.
- DIV, REM: 11.
- DIVU, REMU: 10.

Result select from MC_Result:
- MUL: lo.
- MULH, MULHU: hi.
- MULHSU: hi − (latched SrcA[31] ? latched SrcB : 0), modulo 2^WIDTH.
- DIV, DIVU: lo.
- REM, REMU: hi.

Fast results:
- Divide by zero: DIV/DIVU give all-ones; REM/REMU give SrcA.
- Overflow: DIV gives 0x80000000; REM gives 0.

Latency:
- Fast path: 2 cycles (IDLE, DONE).
- Normal path: 1 + busy cycles + 1.

Simultaneous events:
- MC_Busy=0 on the same cycle the counter reaches TIMEOUT-1: completion wins, no Timeout.

Decomposition:
- Shared package mdu_pkg holds:
  - Funct3 encodings for the eight M ops.
  - MCycleOp encodings.
  - State encoding IDLE/WAIT/DONE.
  - Constant for the signed-overflow dividend 0x80000000.
- No sub-module needed. The result-select/correction mux can be a function in mdu_pkg.

Test Plan:
- MUL, SrcA=7, SrcB=6, MCycle model busy 4 cycles:
  - Start high in cycle 0 only; Stall high cycles 0–4.
  - MWrite in cycle 5 with MResult=42.
- MULHSU, SrcA=0xFFFFFFFF, SrcB=2:
  - MCycleOp=00 and MC_Result=0x1_FFFFFFFE.
  - MResult = 1 − 2 = 0xFFFFFFFF.
- DIVU, SrcB=0: no Start; MWrite in cycle 1 with MResult=0xFFFFFFFF.
- REM, SrcA=0x80000000, SrcB=0xFFFFFFFF: no Start; MResult=0.
- DIV, SrcA=−20, SrcB=3, busy 33 cycles: MCycleOp=11; MResult=0xFFFFFFFA.
- Busy stuck high, TIMEOUT=64:
  - MWrite at cycle 65 with MResult=0, Timeout=1.
- Separately: Reset asserted mid-WAIT:
  - Stall, Start, MWrite and Timeout go to 0 immediately; no MWrite follows.
